// File: rtl/stopwatch_timer.sv
// MM:SS stopwatch / countdown timer with BCD preset load, per-field adjust,
// pause toggle and lap hold. Drives four BCD digits plus status flags.
module stopwatch_timer #(
  parameter int MAX_MIN = 59,
  parameter bit WRAP    = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_tick,
  input  logic        i_tick_adj,
  input  logic        i_pause_btn,
  input  logic        i_lap_btn,
  input  logic        i_adj,
  input  logic        i_sel,
  input  logic        i_mode,
  input  logic        i_load,
  input  logic [15:0] i_preset,
  output logic [3:0]  o_min_tens,
  output logic [3:0]  o_min_ones,
  output logic [3:0]  o_sec_tens,
  output logic [3:0]  o_sec_ones,
  output logic        o_paused,
  output logic        o_lap_active,
  output logic        o_done
);

  localparam logic [3:0] MAX_MT  = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MO  = 4'(MAX_MIN % 10);
  localparam logic [7:0] MAX_M8  = 8'(MAX_MIN);

  logic [3:0]  r_mt, r_mo, r_st, r_so;
  logic [15:0] r_snap;
  logic        r_paused, r_lap_active, r_done;
  logic        r_pause_q, r_lap_q;

  logic        w_pause_edge, w_lap_edge;
  logic [7:0]  w_pre_min;
  logic        w_load_ok;
  logic        w_min_max, w_at_max, w_at_zero;
  logic [15:0] w_cnt, w_up, w_dn, w_adj_min, w_adj_sec;
  logic        w_dn_zero;

  assign w_cnt        = {r_mt, r_mo, r_st, r_so};
  assign w_pause_edge = i_pause_btn & ~r_pause_q;
  assign w_lap_edge   = i_lap_btn & ~r_lap_q;

  // Minutes compared as a binary value so any MAX_MIN in 1..99 works.
  assign w_pre_min = {4'd0, i_preset[15:12]} * 8'd10 + {4'd0, i_preset[11:8]};
  assign w_load_ok = i_load && (i_preset[11:8] <= 4'd9) && (i_preset[3:0] <= 4'd9)
                     && (i_preset[7:4] <= 4'd5) && (w_pre_min <= MAX_M8);

  assign w_min_max = (r_mt == MAX_MT) && (r_mo == MAX_MO);
  assign w_at_max  = w_min_max && (r_st == 4'd5) && (r_so == 4'd9);
  assign w_at_zero = (w_cnt == 16'h0000);
  assign w_dn_zero = (w_dn == 16'h0000);

  always_comb begin
    w_up = w_cnt;
    if (r_so != 4'd9) begin
      w_up[3:0] = r_so + 4'd1;
    end else begin
      w_up[3:0] = 4'd0;
      if (r_st != 4'd5) begin
        w_up[7:4] = r_st + 4'd1;
      end else begin
        w_up[7:4] = 4'd0;
        if (r_mo != 4'd9) begin
          w_up[11:8] = r_mo + 4'd1;
        end else begin
          w_up[11:8]  = 4'd0;
          w_up[15:12] = r_mt + 4'd1;
        end
      end
    end
  end

  always_comb begin
    w_dn = w_cnt;
    if (r_so != 4'd0) begin
      w_dn[3:0] = r_so - 4'd1;
    end else begin
      w_dn[3:0] = 4'd9;
      if (r_st != 4'd0) begin
        w_dn[7:4] = r_st - 4'd1;
      end else begin
        w_dn[7:4] = 4'd5;
        if (r_mo != 4'd0) begin
          w_dn[11:8] = r_mo - 4'd1;
        end else begin
          w_dn[11:8]  = 4'd9;
          w_dn[15:12] = r_mt - 4'd1;
        end
      end
    end
  end

  // Adjust steps touch only the selected field; no carry between fields.
  always_comb begin
    w_adj_min = w_cnt;
    if (w_min_max) begin
      w_adj_min[15:8] = 8'h00;
    end else if (r_mo == 4'd9) begin
      w_adj_min[15:12] = r_mt + 4'd1;
      w_adj_min[11:8]  = 4'd0;
    end else begin
      w_adj_min[11:8] = r_mo + 4'd1;
    end
  end

  always_comb begin
    w_adj_sec = w_cnt;
    if ((r_st == 4'd5) && (r_so == 4'd9)) begin
      w_adj_sec[7:0] = 8'h00;
    end else if (r_so == 4'd9) begin
      w_adj_sec[7:4] = r_st + 4'd1;
      w_adj_sec[3:0] = 4'd0;
    end else begin
      w_adj_sec[3:0] = r_so + 4'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      {r_mt, r_mo, r_st, r_so} <= 16'h0000;
      r_snap       <= 16'h0000;
      r_paused     <= 1'b0;
      r_lap_active <= 1'b0;
      r_done       <= 1'b0;
      r_pause_q    <= 1'b0;
      r_lap_q      <= 1'b0;
    end else begin
      r_pause_q <= i_pause_btn;
      r_lap_q   <= i_lap_btn;

      if (w_pause_edge) r_paused <= ~r_paused;

      // Snapshot takes the pre-update count when a tick coincides.
      if (w_lap_edge) begin
        if (!r_lap_active) begin
          r_snap       <= w_cnt;
          r_lap_active <= 1'b1;
        end else begin
          r_lap_active <= 1'b0;
        end
      end

      if (w_load_ok) begin
        {r_mt, r_mo, r_st, r_so} <= i_preset;
        r_done       <= 1'b0;
        r_lap_active <= 1'b0;
      end else if (i_adj) begin
        if (i_tick_adj) begin
          {r_mt, r_mo, r_st, r_so} <= i_sel ? w_adj_sec : w_adj_min;
          r_done <= 1'b0;
        end
      end else if (i_tick && !r_paused) begin
        if (!i_mode) begin
          if (w_at_max) begin
            if (WRAP) {r_mt, r_mo, r_st, r_so} <= 16'h0000;
            else      r_done <= 1'b1;
          end else begin
            {r_mt, r_mo, r_st, r_so} <= w_up;
          end
        end else if (!w_at_zero) begin
          {r_mt, r_mo, r_st, r_so} <= w_dn;
          if (w_dn_zero) r_done <= 1'b1;
        end
      end
    end
  end

  assign {o_min_tens, o_min_ones, o_sec_tens, o_sec_ones} = r_lap_active ? r_snap : w_cnt;
  assign o_paused     = r_paused;
  assign o_lap_active = r_lap_active;
  assign o_done       = r_done;

endmodule

// File: tb/tb_stopwatch_timer.sv
// Table-driven bench for stopwatch_timer: WRAP=1 and WRAP=0 instances share
// stimulus; expected {digits, paused, lap_active, done} go through a queue.
module tb_stopwatch_timer;

  localparam int OP_TICK  = 0;
  localparam int OP_LOAD  = 1;
  localparam int OP_MODE  = 2;
  localparam int OP_ADJ   = 3;
  localparam int OP_ADJTK = 4;
  localparam int OP_PHOLD = 5;
  localparam int OP_PRESS = 6;
  localparam int OP_PTICK = 7;
  localparam int OP_LAP   = 8;
  localparam int OP_LTICK = 9;

  typedef struct {
    int          op;
    logic [15:0] arg;
    int          n;
    logic [18:0] e1;
    logic [18:0] e0;
  } vec_t;

  typedef struct {
    int          row;
    logic [18:0] e1;
    logic [18:0] e0;
  } sb_t;

  logic        clk, rst_n;
  logic        tick, tick_adj, pause_btn, lap_btn, adj, sel, mode, load;
  logic [15:0] preset;
  logic [3:0]  mt1, mo1, st1, so1, mt0, mo0, st0, so0;
  logic        p1, l1, d1, p0, l0, d0;

  vec_t tbl[$];
  sb_t  sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  stopwatch_timer #(.MAX_MIN(59), .WRAP(1'b1)) u_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_tick_adj(tick_adj),
    .i_pause_btn(pause_btn), .i_lap_btn(lap_btn), .i_adj(adj), .i_sel(sel),
    .i_mode(mode), .i_load(load), .i_preset(preset),
    .o_min_tens(mt1), .o_min_ones(mo1), .o_sec_tens(st1), .o_sec_ones(so1),
    .o_paused(p1), .o_lap_active(l1), .o_done(d1));

  stopwatch_timer #(.MAX_MIN(59), .WRAP(1'b0)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_tick_adj(tick_adj),
    .i_pause_btn(pause_btn), .i_lap_btn(lap_btn), .i_adj(adj), .i_sel(sel),
    .i_mode(mode), .i_load(load), .i_preset(preset),
    .o_min_tens(mt0), .o_min_ones(mo0), .o_sec_tens(st0), .o_sec_ones(so0),
    .o_paused(p0), .o_lap_active(l0), .o_done(d0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(int op, logic [15:0] arg, int n, logic [15:0] dg,
                              logic p, logic l, logic dn, logic [15:0] dg0, logic dn0);
    vec_t v;
    v.op  = op;
    v.arg = arg;
    v.n   = n;
    v.e1  = {dg, p, l, dn};
    v.e0  = {dg0, p, l, dn0};
    tbl.push_back(v);
  endfunction

  function automatic void add_s(int op, logic [15:0] arg, int n, logic [15:0] dg,
                                logic p, logic l, logic dn);
    add(op, arg, n, dg, p, l, dn, dg, dn);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pop(input string nm);
    sb_t         s;
    logic [18:0] g1, g0;
    s  = sbq.pop_front();
    g1 = {mt1, mo1, st1, so1, p1, l1, d1};
    g0 = {mt0, mo0, st0, so0, p0, l0, d0};
    n_cmp++;
    if (g1 !== s.e1) begin
      n_bad++;
      $display("FAIL %s row%0d wrap1 {digits,paused,lap,done}: got %h_%b required %h_%b",
               nm, s.row, g1[18:3], g1[2:0], s.e1[18:3], s.e1[2:0]);
    end
    n_cmp++;
    if (g0 !== s.e0) begin
      n_bad++;
      $display("FAIL %s row%0d wrap0 {digits,paused,lap,done}: got %h_%b required %h_%b",
               nm, s.row, g0[18:3], g0[2:0], s.e0[18:3], s.e0[2:0]);
    end
  endtask

  task automatic apply(input vec_t v);
    case (v.op)
      OP_TICK: repeat (v.n) begin tick = 1'b1; cyc(); tick = 1'b0; cyc(); end
      OP_LOAD: begin preset = v.arg; load = 1'b1; cyc(); load = 1'b0; cyc(); end
      OP_MODE: begin mode = v.arg[0]; cyc(); end
      OP_ADJ: begin
        adj = 1'b1; sel = v.arg[0]; cyc();
        repeat (v.n) begin tick_adj = 1'b1; cyc(); tick_adj = 1'b0; cyc(); end
        adj = 1'b0; cyc();
      end
      OP_ADJTK: begin
        adj = 1'b1; sel = 1'b0; cyc();
        repeat (v.n) begin tick = 1'b1; cyc(); tick = 1'b0; cyc(); end
        adj = 1'b0; cyc();
      end
      OP_PHOLD: begin
        for (int i = 0; i < 20; i++) begin
          pause_btn = 1'b1; tick = (i % 2 == 1); cyc();
        end
        tick = 1'b0; pause_btn = 1'b0; cyc();
      end
      OP_PRESS: begin pause_btn = 1'b1; cyc(); cyc(); pause_btn = 1'b0; cyc(); end
      OP_PTICK: begin
        pause_btn = 1'b1; tick = 1'b1; cyc(); tick = 1'b0; cyc(); pause_btn = 1'b0; cyc();
      end
      OP_LAP: begin lap_btn = 1'b1; cyc(); cyc(); cyc(); lap_btn = 1'b0; cyc(); end
      OP_LTICK: begin
        lap_btn = 1'b1; tick = 1'b1; cyc(); tick = 1'b0; cyc(); lap_btn = 1'b0; cyc();
      end
      default: cyc();
    endcase
  endtask

  function automatic string opn(int op);
    case (op)
      OP_TICK:  return "tick";
      OP_LOAD:  return "load";
      OP_MODE:  return "mode";
      OP_ADJ:   return "adjust";
      OP_ADJTK: return "tick_in_adjust";
      OP_PHOLD: return "pause_held";
      OP_PRESS: return "pause_press";
      OP_PTICK: return "pause_with_tick";
      OP_LAP:   return "lap_press";
      OP_LTICK: return "lap_with_tick";
      default:  return "unknown";
    endcase
  endfunction

  initial begin
    sb_t s;
    rst_n = 1'b0; tick = 1'b0; tick_adj = 1'b0; pause_btn = 1'b0; lap_btn = 1'b0;
    adj = 1'b0; sel = 1'b0; mode = 1'b0; load = 1'b0; preset = 16'h0000;

    // op, arg, n, wrap1 digits, paused, lap, done, [wrap0 digits, wrap0 done]
    add_s(OP_TICK,  0,       65, 16'h0105, 0, 0, 0);
    add_s(OP_LOAD,  16'h5958, 0, 16'h5958, 0, 0, 0);
    add  (OP_TICK,  0,        2, 16'h0000, 0, 0, 0, 16'h5959, 1);
    add  (OP_TICK,  0,        3, 16'h0003, 0, 0, 0, 16'h5959, 1);
    add  (OP_MODE,  1,        0, 16'h0003, 0, 0, 0, 16'h5959, 1);
    add_s(OP_LOAD,  16'h0100, 0, 16'h0100, 0, 0, 0);
    add_s(OP_TICK,  0,        1, 16'h0059, 0, 0, 0);
    add_s(OP_LOAD,  16'h0002, 0, 16'h0002, 0, 0, 0);
    add_s(OP_TICK,  0,        2, 16'h0000, 0, 0, 1);
    add_s(OP_TICK,  0,        3, 16'h0000, 0, 0, 1);
    add_s(OP_LOAD,  16'h0030, 0, 16'h0030, 0, 0, 0);
    add_s(OP_MODE,  0,        0, 16'h0030, 0, 0, 0);
    add_s(OP_PHOLD, 0,        0, 16'h0030, 1, 0, 0);
    add_s(OP_TICK,  0,        4, 16'h0030, 1, 0, 0);
    add_s(OP_PRESS, 0,        0, 16'h0030, 0, 0, 0);
    add_s(OP_TICK,  0,        5, 16'h0035, 0, 0, 0);
    add_s(OP_PTICK, 0,        0, 16'h0036, 1, 0, 0);
    add_s(OP_TICK,  0,        2, 16'h0036, 1, 0, 0);
    add_s(OP_PRESS, 0,        0, 16'h0036, 0, 0, 0);
    add_s(OP_LOAD,  16'h5830, 0, 16'h5830, 0, 0, 0);
    add_s(OP_ADJ,   0,        3, 16'h0130, 0, 0, 0);
    add_s(OP_LOAD,  16'h0058, 0, 16'h0058, 0, 0, 0);
    add_s(OP_ADJ,   1,        3, 16'h0001, 0, 0, 0);
    add_s(OP_ADJTK, 0,        3, 16'h0001, 0, 0, 0);
    add_s(OP_LOAD,  16'h0960, 0, 16'h0001, 0, 0, 0);
    add_s(OP_LOAD,  16'h6000, 0, 16'h0001, 0, 0, 0);
    add_s(OP_LOAD,  16'h5959, 0, 16'h5959, 0, 0, 0);
    add  (OP_TICK,  0,        1, 16'h0000, 0, 0, 0, 16'h5959, 1);
    add_s(OP_LOAD,  16'h0001, 0, 16'h0001, 0, 0, 0);
    add_s(OP_MODE,  1,        0, 16'h0001, 0, 0, 0);
    add_s(OP_TICK,  0,        1, 16'h0000, 0, 0, 1);
    add_s(OP_ADJ,   1,        1, 16'h0001, 0, 0, 0);
    add_s(OP_MODE,  0,        0, 16'h0001, 0, 0, 0);
    add_s(OP_LOAD,  16'h0010, 0, 16'h0010, 0, 0, 0);
    add_s(OP_LAP,   0,        0, 16'h0010, 0, 1, 0);
    add_s(OP_TICK,  0,        5, 16'h0010, 0, 1, 0);
    add_s(OP_LAP,   0,        0, 16'h0015, 0, 0, 0);
    add_s(OP_TICK,  0,        5, 16'h0020, 0, 0, 0);
    add_s(OP_LTICK, 0,        0, 16'h0020, 0, 1, 0);
    add_s(OP_LAP,   0,        0, 16'h0021, 0, 0, 0);
    add_s(OP_LAP,   0,        0, 16'h0021, 0, 1, 0);
    add_s(OP_LOAD,  16'h0100, 0, 16'h0100, 0, 0, 0);
    add_s(OP_TICK,  0,        3, 16'h0103, 0, 0, 0);
    add_s(OP_PRESS, 0,        0, 16'h0103, 1, 0, 0);
    add_s(OP_LAP,   0,        0, 16'h0103, 1, 1, 0);

    #12;
    s.row = -1; s.e1 = 19'h0; s.e0 = 19'h0;
    sbq.push_back(s);
    check_pop("reset_state");
    rst_n = 1'b1;
    cyc();

    foreach (tbl[i]) begin
      s.row = i; s.e1 = tbl[i].e1; s.e0 = tbl[i].e0;
      sbq.push_back(s);
      apply(tbl[i]);
      @(negedge clk);
      check_pop(opn(tbl[i].op));
      cyc();
    end

    // Asynchronous reset must clear everything before the next clock edge.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    s.row = -2; s.e1 = 19'h0; s.e0 = 19'h0;
    sbq.push_back(s);
    #1;
    check_pop("async_reset");
    #3;
    rst_n = 1'b1;
    cyc();

    s.row = -3; s.e1 = {16'h0001, 3'b000}; s.e0 = {16'h0001, 3'b000};
    sbq.push_back(s);
    tick = 1'b1; cyc(); tick = 1'b0; cyc();
    @(negedge clk);
    check_pop("after_reset_tick");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_timer.md
Name: stopwatch_timer

Overview:
Parametrised single-clock successor to the MM:SS stopwatch counter. Counts up as a stopwatch or down as a timer on a 1 Hz enable strobe. Supports BCD preset load, per-field adjust, pause toggle and lap hold. Drives four BCD digits to the seven-segment display driver, plus status flags.

Parameters:
MAX_MIN, 59, largest minute value, legal range 1..99; minute field wraps or saturates here.
WRAP, 1, up-mode overflow behaviour: 1 = wrap MAX_MIN:59 -> 00:00; 0 = saturate and assert done.

Ports:
clk  in  1  system clock; the only clock in the block.
rst  in  1  asynchronous, active-low reset.
tick  in  1  1 Hz one-cycle enable strobe for counting.
tick_adj  in  1  2 Hz one-cycle enable strobe for adjust stepping.
pause_btn  in  1  debounced level; each rising edge toggles pause.
lap_btn  in  1  debounced level; each rising edge toggles lap hold.
adj  in  1  1 = adjust mode.
sel  in  1  adjust field select: 1 = seconds, 0 = minutes.
mode  in  1  0 = count up, 1 = count down.
load  in  1  one-cycle strobe that loads preset.
preset  in  16  BCD {min_tens, min_ones, sec_tens, sec_ones}.
min_tens, min_ones, sec_tens, sec_ones  out  4 each  displayed BCD digits.
paused  out  1  registered pause state.
lap_active  out  1  display frozen on lap snapshot.
done  out  1  sticky terminal-count flag.

Behaviour:
- Reset (rst=0, asynchronous): count = 00:00, lap snapshot = 00:00, paused=0, lap_active=0, done=0, edge-detect registers = 0.
- Edge detect: edge = btn & ~btn_q, where btn_q is registered each clk. A held button produces exactly one toggle.
- Per-cycle priority: load > adjust (adj=1) > count (adj=0).
- load:
  - Preset is legal only if every ones digit <= 9, sec_tens <= 5, and minutes <= MAX_MIN.
  - Legal preset: count <= preset, done <= 0, lap_active <= 0.
  - Illegal preset: load is ignored entirely.
- Adjust:
  - Applies when adj=1 and tick_adj=1, regardless of paused.
  - sel=1: seconds step +1 and wrap 59 -> 00; minutes are unaffected.
  - sel=0: minutes step +1 and wrap MAX_MIN -> 00; seconds are unaffected.
  - done <= 0 on any adjust step.
  - tick is ignored while adj=1.
- Count up (adj=0, paused=0, tick=1, mode=0):
  - BCD increment with carry: sec_ones 9 -> 0 carries to sec_tens; sec_tens 5 -> 0 carries to minutes; min_ones 9 -> 0 carries to min_tens.
  - At MAX_MIN:59 with WRAP=1: next value is 00:00, done unchanged.
  - At MAX_MIN:59 with WRAP=0: count holds, done <= 1.
- Count down (mode=1):
  - BCD decrement with borrow: sec_ones 0 -> 9; sec_tens 0 -> 5; min_ones 0 -> 9.
  - The tick that produces 00:00 sets done <= 1.
  - At 00:00, ticks have no effect.
- mode may change at any time and takes effect on the next tick. Changing mode does not clear done; only load, adjust or reset clear it.
- Pause:
  - A pause edge toggles paused on that clock.
  - A tick in the same cycle uses the pre-toggle paused value.
  - When paused=1, ticks are ignored; load and adjust still operate.
- Lap:
  - Lap edge with lap_active=0: snapshot <= current count (pre-update value if tick coincides), lap_active <= 1.
  - Lap edge with lap_active=1: lap_active <= 0.
  - Internal counting continues throughout lap hold.
- Outputs:
  - Digits are combinational from registers: lap_active ? snapshot : count.
  - Latency from tick to visible digit change is 1 clk.
  - Internal minutes are held as two BCD digits; the MAX_MIN tens/ones split is computed at elaboration.
- All state updates on posedge clk except reset.

Test Plan:
1. Reset, mode=0, 65 tick strobes -> digits 01:05, done=0. Assert rst=0 mid-count -> 00:00 immediately, without waiting for clk.
2. WRAP=1, load 59:58, 2 ticks -> 00:00, done=0. WRAP=0 instance: same stimulus -> holds 59:59, done=1; further ticks change nothing.
3. mode=1, load 01:00, 1 tick -> 00:59. Load 00:02, 2 ticks -> 00:00, done=1; 3 more ticks -> still 00:00. Load 00:30 -> done=0.
4. pause_btn held high 20 clks while 10 ticks arrive -> paused=1, count unchanged; second press -> counting resumes. Pause edge coincident with tick -> that tick still counts.
5. adj=1, sel=0 from 58:30, 3 tick_adj -> 01:30. sel=1 from 00:58, 3 tick_adj -> 00:01, minutes unchanged. A tick strobe during adjust has no effect. Load of preset 16'h0960 is ignored.
6. At 00:10 press lap, 5 ticks -> display 00:10, lap_active=1. Press again -> display 00:15, lap_active=0. Lap edge coincident with tick at 00:20 -> snapshot 00:20.
